// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: merges load and ALU results into one register-file write per cycle,
// parking ALU results that lose to a load in an in-order queue, with pending-write forwarding.
module wb_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rw_addr,
  input  logic [DATA_WIDTH-1:0] alu_rw_data,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_rw_addr,
  input  logic [DATA_WIDTH-1:0] mem_rw_data,
  input  logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  alu_stall,
  output logic                  overflow,
  output logic                  uses_rw,
  output logic [ADDR_WIDTH-1:0] rw_addr,
  output logic [DATA_WIDTH-1:0] rw_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] q_addr_reg [DEPTH];
  logic [DATA_WIDTH-1:0] q_data_reg [DEPTH];
  logic [DEPTH-1:0]      q_vld_reg;
  logic [DEPTH-1:0]      q_vld_next;
  logic [PTR_W-1:0]      head_reg;
  logic [PTR_W-1:0]      tail_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic                  overflow_reg;
  logic                  uses_rw_reg;
  logic [ADDR_WIDTH-1:0] rw_addr_reg;
  logic [DATA_WIDTH-1:0] rw_data_reg;

  logic alu_in;
  logic mem_in;
  logic q_empty;
  logic q_full;
  logic deq;
  logic alu_direct;
  logic alu_enq_req;
  logic enq;
  logic drop;
  logic enq_vld;

  logic                  sel_valid;
  logic                  sel_update;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Register 0 is hard-wired, so writes to it are filtered before anything else sees them.
  assign alu_in      = alu_valid && (alu_rw_addr != '0);
  assign mem_in      = mem_valid && (mem_rw_addr != '0);
  assign q_empty     = (count_reg == '0);
  assign q_full      = (count_reg == CNT_W'(DEPTH));
  assign deq         = !mem_in && !q_empty;
  assign alu_direct  = alu_in && !mem_in && q_empty;
  assign alu_enq_req = alu_in && !alu_direct;
  assign enq         = alu_enq_req && (!q_full || deq);
  assign drop        = alu_enq_req && q_full && !deq;
  // The load is younger than a same-cycle ALU result, so a matching ALU entry is born dead.
  assign enq_vld     = !(mem_in && (alu_rw_addr == mem_rw_addr));

  assign count_next = count_reg + CNT_W'(enq) - CNT_W'(deq);
  assign alu_stall  = (count_reg >= CNT_W'(DEPTH - 1));

  always_comb begin
    sel_valid  = 1'b0;
    sel_update = 1'b0;
    sel_addr   = rw_addr_reg;
    sel_data   = rw_data_reg;
    if (mem_in) begin
      sel_valid  = 1'b1;
      sel_update = 1'b1;
      sel_addr   = mem_rw_addr;
      sel_data   = mem_rw_data;
    end else if (!q_empty) begin
      sel_valid = q_vld_reg[head_reg];
      if (q_vld_reg[head_reg]) begin
        sel_update = 1'b1;
        sel_addr   = q_addr_reg[head_reg];
        sel_data   = q_data_reg[head_reg];
      end
    end else if (alu_in) begin
      sel_valid  = 1'b1;
      sel_update = 1'b1;
      sel_addr   = alu_rw_addr;
      sel_data   = alu_rw_data;
    end
  end

  logic [DEPTH-1:0] inv_match;
  logic [PTR_W-1:0] fwd_idx [DEPTH];
  logic [DEPTH-1:0] fwd_match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign inv_match[gi] = mem_in && (q_addr_reg[gi] == mem_rw_addr);

      // Enqueue is applied last so a full queue can retire and refill the same slot.
      assign q_vld_next[gi] =
          (enq && (tail_reg == PTR_W'(gi))) ? enq_vld :
          (deq && (head_reg == PTR_W'(gi))) ? 1'b0    :
          (q_vld_reg[gi] && !inv_match[gi]);

      // Offset gi counts back from the youngest entry (tail-1).
      assign fwd_idx[gi]   = tail_reg - PTR_W'(gi + 1);
      assign fwd_match[gi] = (CNT_W'(gi) < count_reg) && q_vld_reg[fwd_idx[gi]] &&
                             (q_addr_reg[fwd_idx[gi]] == fwd_addr);
    end
  endgenerate

  // Later assignments win, so sources are visited oldest first.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (uses_rw_reg && (rw_addr_reg == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = rw_data_reg;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (fwd_match[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = q_data_reg[fwd_idx[i]];
      end
    end
    if (alu_in && (alu_rw_addr == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = alu_rw_data;
    end
    if (mem_in && (mem_rw_addr == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = mem_rw_data;
    end
    if (fwd_addr == '0) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr_reg[tail_reg] <= alu_rw_addr;
      q_data_reg[tail_reg] <= alu_rw_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      q_vld_reg    <= '0;
      overflow_reg <= 1'b0;
      uses_rw_reg  <= 1'b0;
      rw_addr_reg  <= '0;
      rw_data_reg  <= '0;
    end else begin
      q_vld_reg   <= q_vld_next;
      count_reg   <= count_next;
      uses_rw_reg <= sel_valid;
      if (enq) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (deq) begin
        head_reg <= head_reg + 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      if (sel_update) begin
        rw_addr_reg <= sel_addr;
        rw_data_reg <= sel_data;
      end
    end
  end

  assign overflow = overflow_reg;
  assign uses_rw  = uses_rw_reg;
  assign rw_addr  = rw_addr_reg;
  assign rw_data  = rw_data_reg;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected writes are queued as stimulus is driven and
// matched against every uses_rw pulse by a monitor.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rw_addr;
  logic [31:0] alu_rw_data;
  logic        mem_valid;
  logic [4:0]  mem_rw_addr;
  logic [31:0] mem_rw_data;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        alu_stall;
  logic        overflow;
  logic        uses_rw;
  logic [4:0]  rw_addr;
  logic [31:0] rw_data;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rw_addr(alu_rw_addr), .alu_rw_data(alu_rw_data),
    .mem_valid(mem_valid), .mem_rw_addr(mem_rw_addr), .mem_rw_data(mem_rw_data),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .alu_stall(alu_stall), .overflow(overflow),
    .uses_rw(uses_rw), .rw_addr(rw_addr), .rw_data(rw_data)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    alu_valid   = av;
    alu_rw_addr = aa;
    alu_rw_data = ad;
    mem_valid   = mv;
    mem_rw_addr = ma;
    mem_rw_data = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  // Every write-back pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && uses_rw) begin
      wr_t w;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=r%0d/0x%0h expected=none", rw_addr, rw_data);
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        $display("wb write r%0d = 0x%08h (expected r%0d = 0x%08h)", rw_addr, rw_data, w.a, w.d);
        check("wb_addr", rw_addr, w.a);
        check("wb_data", rw_data, w.d);
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [31:0] wrap_d [3];

    rst_n    = 1'b0;
    fwd_addr = '0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_uses_rw", uses_rw, 0);
    check("rst_rw_addr", rw_addr, 0);
    check("rst_rw_data", rw_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_alu_stall", alu_stall, 0);
    rst_n = 1'b1;
    tick();

    // Direct ALU write with the queue empty, then a write to r0.
    drive(1, 5, 32'h11, 0, 0, 0);
    push(5, 32'h11);
    tick();
    check("direct_uses_rw", uses_rw, 1);
    drive(1, 0, 32'h11, 0, 0, 0);
    fwd_addr = 0;
    #1;
    check("fwd_r0_hit", fwd_hit, 0);
    check("fwd_r0_data", fwd_data, 0);
    tick();
    check("r0_uses_rw", uses_rw, 0);
    check("r0_hold_addr", rw_addr, 5);
    check("r0_hold_data", rw_data, 32'h11);

    // Load wins over a same-cycle ALU result, which is queued behind it.
    drive(1, 4, 32'hBB, 1, 3, 32'hAA);
    push(3, 32'hAA);
    push(4, 32'hBB);
    fwd_addr = 3;
    #1;
    check("fwd_mem_in_data", fwd_data, 32'hAA);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    fwd_addr = 4;
    #1;
    check("fwd_queued_hit", fwd_hit, 1);
    check("fwd_queued_data", fwd_data, 32'hBB);
    fwd_addr = 3;
    #1;
    check("fwd_staged_hit", fwd_hit, 1);
    check("fwd_staged_data", fwd_data, 32'hAA);
    tick();
    fwd_addr = 6;
    #1;
    check("fwd_miss_hit", fwd_hit, 0);
    check("fwd_miss_data", fwd_data, 0);
    drain("drain_mem_alu", 10);

    // A load to r7 kills the older queued ALU write to r7.
    drive(1, 7, 32'h1, 1, 8, 32'h80);
    push(8, 32'h80);
    tick();
    drive(0, 0, 0, 1, 7, 32'h2);
    push(7, 32'h2);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    fwd_addr = 7;
    #1;
    check("fwd_inval_hit", fwd_hit, 1);
    check("fwd_inval_data", fwd_data, 32'h2);
    tick();
    check("inval_slot_uses_rw", uses_rw, 0);
    drain("drain_inval", 10);

    // Loads every cycle fill the queue: stall at 3, overflow on the fifth ALU result.
    for (int k = 0; k < 5; k++) begin
      drive(1, 5'(10 + k), 32'h100 + k, 1, 5'(16 + k), 32'h200 + k);
      push(5'(16 + k), 32'h200 + k);
      tick();
      check($sformatf("stall_k%0d", k), alu_stall, (k >= 2) ? 1 : 0);
      check($sformatf("overflow_k%0d", k), overflow, (k == 4) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) push(5'(10 + k), 32'h100 + k);
    // Full queue: dequeue and enqueue in the same cycle is accepted.
    drive(1, 15, 32'h115, 0, 0, 0);
    push(15, 32'h115);
    fwd_addr = 12;
    #1;
    check("fwd_full_data", fwd_data, 32'h102);
    tick();
    check("full_swap_stall", alu_stall, 1);
    drive(0, 0, 0, 0, 0, 0);
    drain("drain_full", 20);
    check("overflow_sticky", overflow, 1);
    check("stall_after_drain", alu_stall, 0);

    // Pointers have wrapped; fill across the wrap and drain in FIFO order.
    for (int k = 0; k < 3; k++) begin
      wrap_d[k] = $urandom;
      d = $urandom;
      drive(1, 5'(21 + k), wrap_d[k], 1, 5'(24 + k), d);
      push(5'(24 + k), d);
      tick();
    end
    for (int k = 0; k < 3; k++) push(5'(21 + k), wrap_d[k]);
    d = $urandom;
    drive(1, 27, d, 0, 0, 0);
    push(27, d);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    drain("drain_wrap", 20);

    // Asynchronous reset in the middle of a drain discards the rest.
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'(1 + k), 32'h300 + k, 1, 5'(28 + k), 32'h400 + k);
      push(5'(28 + k), 32'h400 + k);
      tick();
    end
    push(1, 32'h300);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    #6;
    rst_n    = 1'b0;
    fwd_addr = 2;
    #1;
    check("arst_uses_rw", uses_rw, 0);
    check("arst_rw_addr", rw_addr, 0);
    check("arst_rw_data", rw_data, 0);
    check("arst_overflow", overflow, 0);
    check("arst_alu_stall", alu_stall, 0);
    check("arst_fwd_hit", fwd_hit, 0);
    check("arst_pending", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) tick();
    check("post_rst_uses_rw", uses_rw, 0);
    check("post_rst_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-back-side producer for the register file's single synchronous write port: merges ALU results and memory-load results into at most one register write per cycle.
- Drives the write-back interface fields uses_rw / rw_addr / rw_data as registered outputs.
- Buffers ALU results that lose arbitration to a load in a small in-order queue.
- Provides a forwarding lookup over pending (queued or staged) writes so decode reads see data not yet in the register array.

Parameters:
- DEPTH, 4, ALU holding-queue entries (power of two, >= 2)
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, architectural register address width

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU result available this cycle
- alu_rw_addr  input  ADDR_WIDTH  ALU destination register
- alu_rw_data  input  DATA_WIDTH  ALU result
- mem_valid  input  1  load result available this cycle
- mem_rw_addr  input  ADDR_WIDTH  load destination register
- mem_rw_data  input  DATA_WIDTH  load data
- fwd_addr  input  ADDR_WIDTH  forwarding lookup address
- fwd_hit  output  1  a pending write to fwd_addr exists
- fwd_data  output  DATA_WIDTH  youngest pending data for fwd_addr
- alu_stall  output  1  upstream must hold the ALU result
- overflow  output  1  sticky error: ALU result arrived while the queue was full
- uses_rw  output  1  write-back enable to the register file
- rw_addr  output  ADDR_WIDTH  write-back address
- rw_data  output  DATA_WIDTH  write-back data

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, at any time including mid-operation):
  - uses_rw=0, rw_addr=0, rw_data=0, overflow=0.
  - Queue emptied (count=0, head=tail=0).
  - Any in-flight entries are discarded.
- Writes to register 0 are discarded on input and never queued or emitted.
- Each cycle, exactly one source is selected with this priority, and its write is registered onto uses_rw/rw_addr/rw_data at the next posedge (latency 1):
  1. mem_valid
  2. queue head
  3. direct alu_valid (only when the queue is empty)
- If nothing is selected, uses_rw=0 next cycle; rw_addr and rw_data hold their previous values.
- ALU ordering:
  - If the queue is non-empty, or mem_valid is asserted, a valid ALU result is enqueued at the tail and does not bypass.
  - Same-cycle dequeue and enqueue is permitted at any count, including DEPTH.
- Load/queue conflict:
  - A load is always younger than every queued ALU entry (in-order pipeline).
  - Accepting mem_valid for address X invalidates all queued entries with address X.
  - Invalidated entries are still dequeued in order but emit uses_rw=0 in their slot.
- alu_stall = (count >= DEPTH-1), combinational from registered count. This gives a one-entry margin for the cycle of stall latency.
- ALU valid with count==DEPTH and no dequeue this cycle: the result is dropped and overflow is set; overflow clears only on reset.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Forwarding (combinational):
  - Search order, youngest first: incoming mem, incoming ALU, queue entries tail-1 down to head (valid ones only), then the staged output register when uses_rw=1.
  - fwd_hit=1 with the first match's data.
  - fwd_addr==0 always gives fwd_hit=0, fwd_data=0.
  - No match gives fwd_hit=0, fwd_data=0.

Test Plan:
- Reset, then alu_valid with addr 5, data 0x11 and the queue empty -> next cycle uses_rw=1, rw_addr=5, rw_data=0x11. Same request to addr 0 -> uses_rw=0.
- Same cycle: mem (addr 3, 0xAA) and ALU (addr 4, 0xBB) -> cycle+1 writes r3=0xAA, cycle+2 writes r4=0xBB. fwd_addr=4 hits 0xBB while queued.
- Queue holds ALU r7=0x1; then a load to r7=0x2 -> r7 written 0x2. The queued r7 slot emits uses_rw=0, and r7 is never rewritten with 0x1.
- DEPTH=4, mem_valid held high with ALU valid every cycle:
  - alu_stall rises when count reaches 3.
  - Ignoring the stall until count==4 and then sending another ALU result -> overflow=1, which stays 1 until rst_n low.
- Queue partly full with pointers wrapped past DEPTH-1 -> entries drain in FIFO order with correct data.
- Assert rst_n low asynchronously mid-drain -> outputs 0 immediately, queue empty, nothing further emitted after release.
